// File: rtl/pipelined_cla_subtractor_if.sv
// Stream bundle for the pipelined subtractor: one operand channel, one result channel.
// A beat moves on a channel only in a cycle where both its valid and its ready are high.
// The producer holds valid and its payload steady until that cycle. Ready may depend on
// the state of the receiver but never on valid from the same channel.
interface pipelined_cla_subtractor_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_d;
  logic        out_bout;
  logic        out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_bin, out_ready,
    input  in_ready, out_valid, out_d, out_bout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_bin, out_ready,
    output in_ready, out_valid, out_d, out_bout, out_ovf
  );
endinterface

// File: rtl/pipelined_cla_subtractor.sv
// Two-stage 16-bit subtractor D = A - B - bin, computed as A + ~B + ~bin with two 8-bit
// carry-lookahead slices; the low-slice carry is the only signal that crosses the stage register.
module pipelined_cla_subtractor (
  input  logic                        clk,
  input  logic                        rst_n,
  pipelined_cla_subtractor_if.slave   bus
);

  // Returns {carry_out, sum}; each carry uses group generate/propagate over the lower bits.
  function automatic logic [8:0] cla8(input logic [7:0] x, input logic [7:0] y, input logic cin);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       gg;
    logic       pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int i = 1; i <= 8; i++) begin
      gg = 1'b0;
      pp = 1'b1;
      for (int j = 0; j < i; j++) begin
        gg = g[j] | (p[j] & gg);
        pp = pp & p[j];
      end
      c[i] = gg | (pp & cin);
    end
    return {c[8], p ^ c[7:0]};
  endfunction

  logic       s1_v_q, s1_v_d;
  logic [7:0] s1_lo_q, s1_lo_d;
  logic       s1_c8_q, s1_c8_d;
  logic [7:0] s1_ahi_q, s1_ahi_d;
  logic [7:0] s1_bnhi_q, s1_bnhi_d;

  logic        s2_v_q, s2_v_d;
  logic [15:0] s2_diff_q, s2_diff_d;
  logic        s2_bout_q, s2_bout_d;
  logic        s2_ovf_q, s2_ovf_d;

  logic       s2_adv;
  logic       in_xfer;
  logic       out_xfer;
  logic [8:0] lo_sum;
  logic [8:0] hi_sum;
  logic       c15;

  assign lo_sum = cla8(bus.in_a[7:0], ~bus.in_b[7:0], ~bus.in_bin);
  assign hi_sum = cla8(s1_ahi_q, s1_bnhi_q, s1_c8_q);
  // Carry into bit 15 recovered from the bit-15 sum and its two operand bits.
  assign c15    = s1_ahi_q[7] ^ s1_bnhi_q[7] ^ hi_sum[7];

  assign s2_adv       = s1_v_q & (~s2_v_q | bus.out_ready);
  assign bus.in_ready = rst_n & (~s1_v_q | s2_adv);
  assign in_xfer      = bus.in_valid & bus.in_ready;
  assign out_xfer     = s2_v_q & bus.out_ready;

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_lo_d   = s1_lo_q;
    s1_c8_d   = s1_c8_q;
    s1_ahi_d  = s1_ahi_q;
    s1_bnhi_d = s1_bnhi_q;
    if (in_xfer) begin
      s1_v_d    = 1'b1;
      s1_lo_d   = lo_sum[7:0];
      s1_c8_d   = lo_sum[8];
      s1_ahi_d  = bus.in_a[15:8];
      s1_bnhi_d = ~bus.in_b[15:8];
    end else if (s2_adv) begin
      s1_v_d = 1'b0;
    end
  end

  always_comb begin
    s2_v_d    = s2_v_q;
    s2_diff_d = s2_diff_q;
    s2_bout_d = s2_bout_q;
    s2_ovf_d  = s2_ovf_q;
    if (s2_adv) begin
      s2_v_d    = 1'b1;
      s2_diff_d = {hi_sum[7:0], s1_lo_q};
      s2_bout_d = ~hi_sum[8];
      s2_ovf_d  = c15 ^ hi_sum[8];
    end else if (out_xfer) begin
      s2_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_lo_q   <= '0;
      s1_c8_q   <= 1'b0;
      s1_ahi_q  <= '0;
      s1_bnhi_q <= '0;
      s2_v_q    <= 1'b0;
      s2_diff_q <= '0;
      s2_bout_q <= 1'b0;
      s2_ovf_q  <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_lo_q   <= s1_lo_d;
      s1_c8_q   <= s1_c8_d;
      s1_ahi_q  <= s1_ahi_d;
      s1_bnhi_q <= s1_bnhi_d;
      s2_v_q    <= s2_v_d;
      s2_diff_q <= s2_diff_d;
      s2_bout_q <= s2_bout_d;
      s2_ovf_q  <= s2_ovf_d;
    end
  end

  assign bus.out_valid = s2_v_q;
  assign bus.out_d     = s2_diff_q;
  assign bus.out_bout  = s2_bout_q;
  assign bus.out_ovf   = s2_ovf_q;

endmodule

// File: tb/tb_pipelined_cla_subtractor.sv
// Bench for pipelined_cla_subtractor: directed table, backpressure and reset sequences,
// streaming and randomized traffic scored against an arithmetic reference model.
module tb_pipelined_cla_subtractor;

  localparam int W = 18;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
  } vec_t;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_cla_subtractor_if bus();

  pipelined_cla_subtractor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  bit           lat_chk = 1'b0;
  bit           rand_or = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain 17-bit unsigned and 32-bit signed arithmetic.
  function automatic logic [W-1:0] ref_sub(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] w;
    int          sd;
    logic        ovf;
    w   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    sd  = int'($signed(a)) - int'($signed(b)) - int'(bin);
    ovf = (sd > 32767) || (sd < -32768);
    return {w[15:0], w[16], ovf};
  endfunction

  // Monitor: every output transfer is matched against the head of the expected queue.
  initial begin : monitor
    logic [W-1:0] e;
    int           c;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got d=%h with no beat outstanding (cycle %0d)", bus.out_d, cyc);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          check("result", 32'({bus.out_d, bus.out_bout, bus.out_ovf}), 32'(e));
          if (lat_chk) check("latency", 32'(cyc - c), 32'd2);
        end
      end
    end
  end

  // Random out_ready generator, active only in the randomized phase.
  initial begin : ready_gen
    forever begin
      @(negedge clk);
      if (rand_or) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Driver tasks
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin,
                      input logic [W-1:0] exp, output int waits);
    waits = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_bin   = bin;
    #1;
    while (!bus.in_ready && waits < 500) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!bus.in_ready) check("accept_timeout", 32'(bus.in_ready), 32'd1);
    else begin
      exp_q.push_back(exp);
      cyc_q.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    while (exp_q.size() != 0 && b < 500) begin
      @(negedge clk);
      #2;
      b++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_d"},     32'(bus.out_d),     32'd0);
    check({tag, "_bout"},      32'(bus.out_bout),  32'd0);
    check({tag, "_ovf"},       32'(bus.out_ovf),   32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
  endtask

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    n_cmp++;
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : main
    vec_t          vecs[10];
    int            w;
    int            stalls;
    logic [15:0]   ra, rb;
    logic          rbin;

    vecs[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[1] = '{16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0};
    vecs[7] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_bin    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed table, one beat at a time, with latency check
    lat_chk = 1'b1;
    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].bin, {vecs[i].d, vecs[i].bout, vecs[i].ovf}, w);
      drain();
    end

    // Streaming: 16 back-to-back beats
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom_range(0, 1));
      send(ra, rb, rbin, ref_sub(ra, rb, rbin), w);
      stalls += w;
    end
    check("stream_no_stall", 32'(stalls), 32'd0);
    drain();
    lat_chk = 1'b0;

    // Backpressure: two beats fill the pipe, third waits
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(16'h0010, 16'h0001, 1'b0, {16'h000F, 1'b0, 1'b0}, w);
    send(16'h0020, 16'h0001, 1'b0, {16'h001F, 1'b0, 1'b0}, w);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 16'h0030;
    bus.in_b     = 16'h0001;
    bus.in_bin   = 1'b0;
    #1;
    check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("bp_out_valid",    32'(bus.out_valid), 32'd1);
    check("bp_out_d",        32'(bus.out_d), 32'h000F);
    repeat (3) @(negedge clk);
    #1;
    check("bp_hold_d",     32'(bus.out_d), 32'h000F);
    check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back({16'h002F, 1'b0, 1'b0});
    cyc_q.push_back(cyc);
    drain();

    // Reset with both stages full
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(16'h4444, 16'h1111, 1'b0, ref_sub(16'h4444, 16'h1111, 1'b0), w);
    send(16'h5555, 16'h2222, 1'b1, ref_sub(16'h5555, 16'h2222, 1'b1), w);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("pre_reset_full", 32'({bus.out_valid, bus.in_ready}), 32'b10);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(5);
    #1;
    check("post_reset_idle", 32'(bus.out_valid), 32'd0);
    send(16'h0300, 16'h0101, 1'b1, ref_sub(16'h0300, 16'h0101, 1'b1), w);
    drain();

    // Randomized traffic
    rand_or = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      case ($urandom_range(0, 3))
        0: begin ra = 16'($urandom); rb = 16'($urandom); end
        1: begin ra = 16'($urandom_range(0, 3)); rb = 16'($urandom_range(0, 3)); end
        2: begin ra = 16'h8000 ^ 16'($urandom_range(0, 3)); rb = 16'($urandom_range(0, 3)); end
        default: begin ra = 16'h7FFF; rb = 16'hFFFF ^ 16'($urandom_range(0, 255)); end
      endcase
      rbin = 1'($urandom_range(0, 1));
      send(ra, rb, rbin, ref_sub(ra, rb, rbin), w);
    end
    drain();
    rand_or = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_subtractor.md
# pipelined_cla_subtractor

Two-stage pipelined 16-bit unsigned/two's-complement subtractor computing D = A − B − bin, built from two 8-bit carry-lookahead slices (A + ~B + ~bin) with a register between them. It is the subtract-side companion to the team's 16-bit CLA adder and sits in the datapath behind a valid/ready stream interface. It reports borrow-out and signed overflow. It sustains one result per cycle under full backpressure support.

## Interface

- No parameters; width is fixed at 16 bits, split as 8 + 8.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block accepts operand beat this cycle
- in_a  input  16  minuend A
- in_b  input  16  subtrahend B
- in_bin  input  1  borrow-in
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result this cycle
- out_d  output  16  difference, A − B − bin mod 2^16
- out_bout  output  1  unsigned borrow-out: 1 iff A < B + bin
- out_ovf  output  1  signed overflow: carry into bit 15 XOR carry out of bit 15 of A + ~B + ~bin

## Operation

- Stage 1 (S1) register captures the following on acceptance:
  - low difference byte, from an 8-bit CLA over A[7:0], ~B[7:0], cin = ~bin;
  - carry c8;
  - A[15:8] and ~B[15:8].
- Stage 2 (S2) register captures the following when S1 advances:
  - high difference byte, from an 8-bit CLA over S1 high operands with cin = c8;
  - the S1 low byte;
  - bout = ~c16;
  - ovf = c15 ^ c16.
- out_d, out_bout, out_ovf and out_valid drive directly from S2 registers.
- Each stage has a valid bit; s1_v and s2_v are internal.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - s2_adv = s1_v & (~s2_v | out_ready).
  - in_ready = ~s1_v | s2_adv. It is combinational, with no dependency on in_valid.
- Stage updates:
  - S2 loads on s2_adv.
  - S2 clears its valid on an output transfer without s2_adv.
  - S1 loads on an input transfer and clears its valid on s2_adv without a new input.
- Stall rule: while out_valid=1 and out_ready=0, out_d, out_bout and out_ovf hold stable.
- Ordering: results leave in acceptance order, with no drops and no duplicates.
- Reset (rst_n low, asynchronous):
  - s1_v, s2_v, out_valid are 0; out_d is 0x0000; out_bout and out_ovf are 0.
  - in_ready is forced to 0 while rst_n is low and returns to 1 in the first cycle after release.
  - Reset mid-stream discards all in-flight beats.

## Timing

- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1, provided S2 is free. That is 2 registered stages.
- Throughput: 1 beat/cycle with out_ready held high.
- Backpressure:
  - With out_ready=0, two beats fill S2 and S1. in_ready then drops to 0 combinationally.
  - One cycle of out_ready=1 drains S2, advances S1, and raises in_ready in that same cycle. No bubble is inserted.
- Simultaneous output transfer and input transfer with both stages full: S2 takes S1 and S1 takes the new beat in one edge.
- Arithmetic: internal sums are 9-bit per slice. The c8 carry crosses the stage register only; no combinational path runs from in_* to out_*.

## Test plan

- Basic subtractions, one beat each, out_ready=1. Each result must appear 2 cycles after acceptance.
  - A=0x0005, B=0x0003, bin=0 → D=0x0002, bout=0, ovf=0.
  - A=0x1000, B=0x0FFF, bin=1 → D=0x0000, bout=0, ovf=0.
- Borrow and overflow corners:
  - A=0x0000, B=0x0001 → 0xFFFF, bout=1, ovf=0.
  - A=0x8000, B=0x0001 → 0x7FFF, bout=0, ovf=1.
  - A=0x7FFF, B=0xFFFF → 0x8000, bout=1, ovf=1.
  - A=0x0000, B=0x0000, bin=1 → 0xFFFF, bout=1, ovf=0.
- Streaming: 16 back-to-back beats with in_valid=1 and out_ready=1. in_ready must stay 1 and results must arrive one per cycle, in order, matching a reference model.
- Backpressure: out_ready=0; send A=0x0010,0x0020,0x0030 with B=0x0001.
  - in_ready must drop after 2 accepts.
  - out_d must hold 0x000F.
  - Raising out_ready must yield 0x000F, 0x001F, 0x002F in order with no loss.
- Reset mid-operation: assert rst_n low with both stages full.
  - out_valid=0, out_d=0x0000 and in_ready=0 must take effect immediately, without waiting for a clock edge.
  - After release, no stale beat may emerge, and the next beat must produce a correct result.
- Randomized out_ready and in_valid, 1000 beats, checked against A − B − bin, bout and ovf computed at 17-bit width.
